// File: rtl/hdmi_line_fetch_if.sv
// Burst read port from the line fetcher to framebuffer memory.
// The fetcher is the master: it issues requests and consumes in-order read beats.
interface hdmi_line_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, mem_len,
                  input  mem_ack, mem_rvalid, mem_rdata);
  modport slave  (input  mem_req, mem_addr, mem_len,
                  output mem_ack, mem_rvalid, mem_rdata);
endinterface

// File: rtl/hdmi_line_fetch.sv
// Framebuffer line fetcher: turns timing-core pulses into burst reads and
// buffers returned pixels in a first-word-fall-through FIFO feeding `color`.
module hdmi_line_fetch #(
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       fb_base,
  input  logic [15:0]       line_stride,
  input  logic [10:0]       hres,
  input  logic              read_go,
  input  logic              read_next_line,
  input  logic              read_next_chunk,
  input  logic              read_done,
  input  logic              read_fifo,
  output logic [31:0]       color,
  output logic              underflow,
  output logic              overflow,
  output logic              busy,
  hdmi_line_fetch_if.master mem
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BSH = $clog2(BURST_LEN) + 2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;

  logic        rst;
  logic [31:0] line_addr, line_eff;
  logic [15:0] stride_q;
  logic [10:0] hres_q, chunk_idx, chunk_eff, words_left, words_eff;
  logic [7:0]  len_eff;
  logic [1:0]  pend, pend_base, pend_n;
  logic [11:0] outst, outst_n;
  logic        go, enter_drain, line_trig, chunk_trig, trig, trig_ok;
  logic        ack_fire, issue_cand, issue, drop;
  logic        req_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;

  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fcnt;
  logic          empty, full, flush, wr_try, do_wr, do_pop;

  assign rst          = reset | ~start;
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign mem.mem_len  = len_q;

  always_comb begin
    go          = read_go && (state != DRAIN);
    enter_drain = read_done && (state == RUN) && !go;
    line_trig   = read_next_line && (state == RUN) && !go && !read_done;
    chunk_trig  = read_next_chunk && (state == RUN) && !go && !read_done &&
                  !read_next_line && (words_left != '0);
    trig        = go | line_trig | chunk_trig;
    ack_fire    = req_q && mem.mem_ack;

    // Values the request generator sees this cycle, including a same-cycle trigger
    line_eff  = line_addr;
    chunk_eff = chunk_idx;
    words_eff = words_left;
    if (go) begin
      line_eff  = fb_base;
      chunk_eff = '0;
      words_eff = hres;
    end else if (line_trig) begin
      line_eff  = line_addr + 32'(stride_q);
      chunk_eff = '0;
      words_eff = hres_q;
    end
    len_eff = (words_eff >= 11'(BURST_LEN)) ? 8'(BURST_LEN) : words_eff[7:0];

    // A restart keeps only the in-flight request, if any
    pend_base  = go ? {1'b0, req_q} : pend;
    trig_ok    = trig && (pend_base != 2'd3);
    issue_cand = !req_q && ((pend_base != '0) || trig_ok) &&
                 (go || ((state == RUN) && !read_done));
    issue      = issue_cand && (words_eff != '0);
    drop       = issue_cand && (words_eff == '0);
    if (enter_drain) pend_n = {1'b0, req_q && !ack_fire};
    else             pend_n = pend_base + 2'(trig_ok) - 2'(ack_fire) - 2'(drop);

    outst_n = outst + (ack_fire ? 12'(len_q) : 12'd0) - 12'(mem.mem_rvalid);

    state_n = state;
    case (state)
      IDLE:    if (go) state_n = RUN;
      RUN:     if (enter_drain) state_n = DRAIN;
      DRAIN:   if ((outst_n == '0) && (pend_n == '0) && !(req_q && !ack_fire)) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    flush  = go || enter_drain;
    empty  = (fcnt == '0);
    full   = (fcnt == (AW+1)'(FIFO_DEPTH));
    wr_try = mem.mem_rvalid && (state == RUN) && !flush;
    do_pop = read_fifo && !empty;
    do_wr  = wr_try && (!full || read_fifo);
    color  = empty ? '0 : fifo_mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      line_addr  <= '0;
      stride_q   <= '0;
      hres_q     <= '0;
      chunk_idx  <= '0;
      words_left <= '0;
      pend       <= '0;
      outst      <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fcnt       <= '0;
      underflow  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state     <= state_n;
      busy      <= (state_n != IDLE);
      pend      <= pend_n;
      outst     <= outst_n;
      line_addr <= line_eff;
      if (go) begin
        stride_q <= line_stride;
        hres_q   <= hres;
      end
      // Chunk bookkeeping advances on issue, not on queueing
      chunk_idx  <= issue ? chunk_eff + 11'd1 : chunk_eff;
      words_left <= issue ? words_eff - 11'(len_eff) : words_eff;
      if (ack_fire) req_q <= 1'b0;
      else if (issue) begin
        req_q  <= 1'b1;
        addr_q <= line_eff + (32'(chunk_eff) << BSH);
        len_q  <= len_eff;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fcnt   <= '0;
      end else begin
        if (do_wr)  wr_ptr <= wr_ptr + AW'(1);
        if (do_pop) rd_ptr <= rd_ptr + AW'(1);
        fcnt <= fcnt + (AW+1)'(do_wr) - (AW+1)'(do_pop);
      end
      if (read_fifo && empty) underflow <= 1'b1;
      if ((wr_try && full && !read_fifo) || (trig && !trig_ok)) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) fifo_mem[wr_ptr] <= mem.mem_rdata;
  end
endmodule
